// File: rtl/data_mem_responder_pkg.sv
// Shared constants for the data-memory responder.
// funct3 access encodings and responder FSM states.
package data_mem_responder_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Sign- or zero-extend a byte.
  function automatic logic [31:0] ext8(
    input logic [7:0] b,
    input logic       uns
  );
    return uns ? {24'b0, b} : {{24{b[7]}}, b};
  endfunction

  // Sign- or zero-extend a half.
  function automatic logic [31:0] ext16(
    input logic [15:0] h,
    input logic        uns
  );
    return uns ? {16'b0, h} : {{16{h[15]}}, h};
  endfunction

endpackage

// File: rtl/data_mem_responder_lsu_align.sv
// Lane alignment for RISC-V byte/half/word accesses.
// Ports: we/func3/lo/wdata/rword in; wmask, wdata_sh, rdata, misalign, illegal out.
module lsu_align
  import data_mem_responder_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  func3,
  input  logic [1:0]  lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        illegal
);

  logic        is_b;
  logic        is_h;
  logic        is_w;
  logic [7:0]  bsel;
  logic [15:0] hsel;

  always_comb begin
    is_b    = 1'b0;
    is_h    = 1'b0;
    is_w    = 1'b0;
    illegal = 1'b1;
    case (func3)
      F3_B: begin
        is_b    = 1'b1;
        illegal = 1'b0;
      end
      F3_H: begin
        is_h    = 1'b1;
        illegal = 1'b0;
      end
      F3_W: begin
        is_w    = 1'b1;
        illegal = 1'b0;
      end
      F3_BU: begin
        is_b    = !we;
        illegal = we;
      end
      F3_HU: begin
        is_h    = !we;
        illegal = we;
      end
      default: ;
    endcase
  end

  assign misalign = (is_h & lo[0])
                  | (is_w & (lo != 2'b00));

  always_comb begin
    case (lo)
      2'd0:    bsel = rword[7:0];
      2'd1:    bsel = rword[15:8];
      2'd2:    bsel = rword[23:16];
      default: bsel = rword[31:24];
    endcase
  end

  assign hsel = lo[1] ? rword[31:16]
                      : rword[15:0];

  // Store data is replicated across lanes;
  // the mask picks the addressed ones.
  always_comb begin
    wmask    = 4'b0000;
    wdata_sh = 32'b0;
    rdata    = 32'b0;
    unique case (1'b1)
      is_b: begin
        wmask    = 4'b0001 << lo;
        wdata_sh = {4{wdata[7:0]}};
        rdata    = ext8(bsel, func3[2]);
      end
      is_h: begin
        wmask    = lo[1] ? 4'b1100 : 4'b0011;
        wdata_sh = {2{wdata[15:0]}};
        rdata    = ext16(hsel, func3[2]);
      end
      is_w: begin
        wmask    = 4'b1111;
        wdata_sh = wdata;
        rdata    = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder with programmable latency and valid/ready handshakes.
// Ports: req_* request channel, resp_* response channel, clk, rst (async high).
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_func3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW =
    (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    CW'(LATENCY - 1);
  localparam logic [29:0] DEPTH_LIM =
    30'(DEPTH_WORDS);

  state_e        state;
  logic [CW-1:0] cnt;
  logic          l_we;
  logic [31:0]   l_addr;
  logic [31:0]   l_wdata;
  logic [2:0]    l_func3;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic          enter_resp;
  logic          a_we;
  logic [31:0]   a_addr;
  logic [31:0]   a_wdata;
  logic [2:0]    a_func3;
  logic          in_range;
  logic [AW-1:0] idx;
  logic [31:0]   rword;
  logic [3:0]    wmask;
  logic [31:0]   wdata_sh;
  logic [31:0]   ld_data;
  logic          misalign;
  logic          illegal;
  logic          err;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  assign accept = (state == IDLE) && req_valid;

  // With single-cycle latency the access happens on
  // the accept edge itself, straight from the inputs.
  assign enter_resp = !rst && (
      (accept && (LATENCY == 1))
    || ((state == WAIT) && (cnt == CW'(1))));

  assign a_we    = (state == IDLE) ? req_we    : l_we;
  assign a_addr  = (state == IDLE) ? req_addr  : l_addr;
  assign a_wdata = (state == IDLE) ? req_wdata : l_wdata;
  assign a_func3 = (state == IDLE) ? req_func3 : l_func3;

  assign in_range = (a_addr[31:2] < DEPTH_LIM);
  assign idx      = a_addr[AW+1:2];
  assign rword    = in_range ? mem[idx] : 32'b0;

  lsu_align u_align (
    .we       (a_we),
    .func3    (a_func3),
    .lo       (a_addr[1:0]),
    .wdata    (a_wdata),
    .rword    (rword),
    .wmask    (wmask),
    .wdata_sh (wdata_sh),
    .rdata    (ld_data),
    .misalign (misalign),
    .illegal  (illegal)
  );

  assign err = illegal | misalign | !in_range;

  // Array is not reset; only complete, legal stores
  // reaching RESP modify it.
  always_ff @(posedge clk) begin
    if (enter_resp && a_we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) begin
          mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      l_we       <= 1'b0;
      l_addr     <= 32'b0;
      l_wdata    <= 32'b0;
      l_func3    <= 3'b0;
      resp_rdata <= 32'b0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            l_we    <= req_we;
            l_addr  <= req_addr;
            l_wdata <= req_wdata;
            l_func3 <= req_func3;
            cnt     <= CNT_INIT;
            state   <= (LATENCY > 1) ? WAIT : RESP;
          end
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_rdata <= 32'b0;
            resp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (enter_resp) begin
        resp_rdata <= (a_we || err) ? 32'b0
                                    : ld_data;
        resp_err   <= err;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder.
// Covers LATENCY=2 table vectors, backpressure, reset, and a LATENCY=1 build.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_func3;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  logic        rv1, rr1, we1, rdy1, vld1, err1;
  logic [31:0] a1, wd1, rd1;
  logic [2:0]  f31;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(
    .DEPTH_WORDS(1024),
    .LATENCY(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_func3  (req_func3),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  data_mem_responder #(
    .DEPTH_WORDS(1024),
    .LATENCY(1)
  ) dut1 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (rv1),
    .req_ready  (rdy1),
    .req_we     (we1),
    .req_addr   (a1),
    .req_wdata  (wd1),
    .req_func3  (f31),
    .resp_valid (vld1),
    .resp_ready (rr1),
    .resp_rdata (rd1),
    .resp_err   (err1)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic        we,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input logic [2:0]  f3,
    input logic [31:0] exp_rd,
    input logic        exp_err
  );
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata;
    v.f3 = f3; v.exp_rd = exp_rd;
    v.exp_err = exp_err;
    return v;
  endfunction

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Called #1 after a rising edge with dut in IDLE.
  task automatic txn(
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [2:0]  f3,
    output logic [31:0] rd,
    output logic        er,
    output int          lat
  );
    int n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    req_func3 = f3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = ~a;
    req_wdata = ~wd;
    req_func3 = ~f3;
    lat = 1;
    while (!resp_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    rd = resp_rdata;
    er = resp_err;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    rst = 1'b1;
    req_valid = 0; req_we = 0; req_addr = 0;
    req_wdata = 0; req_func3 = 0; resp_ready = 0;
    rv1 = 0; rr1 = 0; we1 = 0; a1 = 0;
    wd1 = 0; f31 = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", 32'(resp_err), 32'd0);

    vecs.push_back(mk(1, 32'h10, 32'hDEADBEEF, F3_W, 0, 0));
    vecs.push_back(mk(0, 32'h10, 0, F3_W, 32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 32'h10, 0, F3_W, 0, 0));
    vecs.push_back(mk(1, 32'h11, 32'h80, F3_B, 0, 0));
    vecs.push_back(mk(0, 32'h11, 0, F3_B, 32'hFFFFFF80, 0));
    vecs.push_back(mk(0, 32'h11, 0, F3_BU, 32'h00000080, 0));
    vecs.push_back(mk(0, 32'h10, 0, F3_HU, 32'h00008000, 0));
    vecs.push_back(mk(0, 32'h10, 0, F3_W, 32'h00008000, 0));
    vecs.push_back(mk(0, 32'h10, 0, F3_H, 32'hFFFF8000, 0));
    vecs.push_back(mk(1, 32'h00, 32'h11223344, F3_W, 0, 0));
    vecs.push_back(mk(0, 32'h02, 0, F3_W, 0, 1));
    vecs.push_back(mk(1, 32'h03, 32'hBEEF, F3_H, 0, 1));
    vecs.push_back(mk(0, 32'h00, 0, F3_W, 32'h11223344, 0));
    vecs.push_back(mk(1, 32'h02, 32'h7777AABB, F3_H, 0, 0));
    vecs.push_back(mk(0, 32'h00, 0, F3_W, 32'hAABB3344, 0));
    vecs.push_back(mk(0, 32'h02, 0, F3_HU, 32'h0000AABB, 0));
    vecs.push_back(mk(0, 32'h02, 0, F3_H, 32'hFFFFAABB, 0));
    vecs.push_back(mk(0, 32'h03, 0, F3_B, 32'hFFFFFFAA, 0));
    vecs.push_back(mk(0, 32'h00, 0, F3_BU, 32'h00000044, 0));
    vecs.push_back(mk(0, 32'h00, 0, 3'b011, 0, 1));
    vecs.push_back(mk(0, 32'h00, 0, 3'b110, 0, 1));
    vecs.push_back(mk(1, 32'h00, 0, F3_BU, 0, 1));
    vecs.push_back(mk(1, 32'h00, 0, 3'b011, 0, 1));
    vecs.push_back(mk(0, 32'h00, 0, F3_W, 32'hAABB3344, 0));
    vecs.push_back(mk(0, 32'h1000, 0, F3_W, 0, 1));
    vecs.push_back(mk(1, 32'h1000, 32'h5, F3_W, 0, 1));
    vecs.push_back(mk(1, 32'hFFC, 32'hCAFEF00D, F3_W, 0, 0));
    vecs.push_back(mk(0, 32'hFFC, 0, F3_W, 32'hCAFEF00D, 0));
    vecs.push_back(mk(0, 32'h10, 0, F3_W, 32'h00008000, 0));

    foreach (vecs[i]) begin
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata,
          vecs[i].f3, rd, er, lat);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("v%0d_err", i), 32'(er),
          32'(vecs[i].exp_err));
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'd2);
    end

    // Backpressure with stray requests in RESP.
    req_valid = 1; req_we = 0;
    req_addr = 32'h10; req_func3 = F3_W;
    @(posedge clk); #1;
    req_valid = 0;
    chk("bp_wait_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    chk("bp_resp_valid", 32'(resp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      req_valid = (i % 2 == 0);
      req_we    = 1'b1;
      req_addr  = 32'h0;
      req_wdata = 32'hFFFFFFFF;
      req_func3 = F3_W;
      @(posedge clk); #1;
      chk($sformatf("bp%0d_valid", i), 32'(resp_valid), 32'd1);
      chk($sformatf("bp%0d_ready", i), 32'(req_ready), 32'd0);
      chk($sformatf("bp%0d_rdata", i), resp_rdata, 32'h00008000);
      chk($sformatf("bp%0d_err", i), 32'(resp_err), 32'd0);
    end
    resp_ready = 1; req_valid = 1;
    req_we = 0; req_addr = 32'h0; req_func3 = F3_W;
    @(posedge clk); #1;
    resp_ready = 0;
    chk("bp_rel_valid", 32'(resp_valid), 32'd0);
    chk("bp_rel_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 0;
    chk("bp_acc_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("bp_next_valid", 32'(resp_valid), 32'd1);
    chk("bp_next_rdata", resp_rdata, 32'hAABB3344);
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;

    // Reset during WAIT of a store.
    txn(1, 32'h20, 32'h0BADF00D, F3_W, rd, er, lat);
    req_valid = 1; req_we = 1; req_addr = 32'h20;
    req_wdata = 32'h12345678; req_func3 = F3_W;
    @(posedge clk); #1;
    req_valid = 0;
    chk("rw_in_wait", 32'(req_ready), 32'd0);
    rst = 1;
    #1;
    chk("rw_ready", 32'(req_ready), 32'd1);
    chk("rw_valid", 32'(resp_valid), 32'd0);
    chk("rw_rdata", resp_rdata, 32'h0);
    chk("rw_err", 32'(resp_err), 32'd0);
    @(posedge clk); #1;
    rst = 0;
    txn(0, 32'h20, 0, F3_W, rd, er, lat);
    chk("rw_keep", rd, 32'h0BADF00D);
    chk("rw_keep_err", 32'(er), 32'd0);

    // LATENCY=1 back-to-back.
    rv1 = 1; rr1 = 1; we1 = 1;
    a1 = 32'h4; wd1 = 32'hA5A55A5A; f31 = F3_W;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("l1_%0d_valid", k), 32'(vld1),
          32'(k % 2 == 0));
      chk($sformatf("l1_%0d_ready", k), 32'(rdy1),
          32'(k % 2 == 1));
      if (k == 5) we1 = 0;
      if (k == 6) begin
        chk("l1_rdata", rd1, 32'hA5A55A5A);
        chk("l1_err", 32'(err1), 32'd0);
      end
    end
    rv1 = 0; rr1 = 0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
